instruction_decode_stage: RTL and testbench

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

---
 rtl/instruction_decode_stage.sv | 124 ++++++++++++
 tb/tb_instruction_decode_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: one ID register with hazard control for load-use
// stalls, jump redirection with a configurable squash window, and HALT.
module instruction_decode_stage #(
   parameter int FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ins,
   input  logic [15:0] current_address,
   output logic [15:0] jmp_loc,
   output logic        pc_mux_sel,
   output logic        stall,
   output logic        stall_pm,
   output logic        ex_valid,
   output logic [5:0]  ex_opcode,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic [31:0] ex_imm,
   output logic [15:0] ex_pc
);

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  flush_cnt, flush_cnt_nxt;
   logic [31:0] id_ins, id_ins_nxt;
   logic [15:0] id_pc, id_pc_nxt;
   logic        id_valid, id_valid_nxt;
   logic        stall_int, sel_int;
   logic        load_use;

   logic [5:0] id_op;
   logic [4:0] id_rt;
   assign id_op = id_ins[31:26];
   assign id_rt = id_ins[20:16];

   assign load_use = id_valid && (id_op == OP_LW) && (id_rt != 5'd0) &&
                     ((ins[25:21] == id_rt) || (ins[20:16] == id_rt));

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      id_ins_nxt    = id_ins;
      id_pc_nxt     = id_pc;
      id_valid_nxt  = id_valid;
      stall_int     = 1'b0;
      sel_int       = 1'b0;
      case (state)
         RUN: begin
            if (id_valid && id_op == OP_HALT) begin
               stall_int = 1'b1;
               state_nxt = HALT;
            end else if (id_valid && id_op == OP_J) begin
               sel_int      = 1'b1;
               id_valid_nxt = 1'b0;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt     = FLUSH;
                  flush_cnt_nxt = 2'(FLUSH_CYCLES - 1);
               end
            end else if (load_use) begin
               stall_int    = 1'b1;
               id_valid_nxt = 1'b0;
            end else begin
               id_ins_nxt   = ins;
               id_pc_nxt    = current_address;
               id_valid_nxt = 1'b1;
            end
         end
         FLUSH: begin
            id_valid_nxt  = 1'b0;
            flush_cnt_nxt = flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) begin
               state_nxt = RUN;
            end
         end
         HALT: begin
            stall_int = 1'b1;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= RUN;
         flush_cnt <= 2'd0;
         id_ins    <= 32'd0;
         id_pc     <= 16'd0;
         id_valid  <= 1'b0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         id_ins    <= id_ins_nxt;
         id_pc     <= id_pc_nxt;
         id_valid  <= id_valid_nxt;
      end
   end

   // Reset is synchronous, so outputs are masked while it is asserted to keep
   // the pipeline quiet before the first reset edge has been seen.
   assign stall      = stall_int & reset;
   assign stall_pm   = stall_int & reset;
   assign pc_mux_sel = sel_int & reset;
   assign jmp_loc    = (sel_int && reset) ? id_ins[15:0] : 16'h0000;
   assign ex_valid   = id_valid && (state != HALT) && reset;
   assign ex_opcode  = id_ins[31:26];
   assign ex_rs      = id_ins[25:21];
   assign ex_rt      = id_ins[20:16];
   assign ex_rd      = id_ins[15:11];
   assign ex_imm     = reset ? {{16{id_ins[15]}}, id_ins[15:0]} : 32'd0;
   assign ex_pc      = id_pc;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench: two decode stages (FLUSH_CYCLES 1 and 3) share stimulus;
// per-cycle control expectations and per-instruction decode expectations are queued.
module tb_instruction_decode_stage;

   typedef struct packed {
      logic        v;
      logic        st;
      logic        stpm;
      logic        sel;
      logic [15:0] jmp;
   } ctl_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] imm;
   } ex_t;

   localparam ctl_t CZ = '{v:1'b0, st:1'b0, stpm:1'b0, sel:1'b0, jmp:16'h0000};
   localparam ctl_t CV = '{v:1'b1, st:1'b0, stpm:1'b0, sel:1'b0, jmp:16'h0000};
   localparam ctl_t CS = '{v:1'b1, st:1'b1, stpm:1'b1, sel:1'b0, jmp:16'h0000};
   localparam ctl_t CJ = '{v:1'b1, st:1'b0, stpm:1'b0, sel:1'b1, jmp:16'h0008};
   localparam ctl_t CH = '{v:1'b0, st:1'b1, stpm:1'b1, sel:1'b0, jmp:16'h0000};

   localparam logic [31:0] ADD1  = 32'h00221820;
   localparam logic [31:0] ADD2  = 32'h00432020;
   localparam logic [31:0] LW2   = 32'h8C020004;
   localparam logic [31:0] DEP   = 32'h00421820;
   localparam logic [31:0] J8    = 32'h08000008;
   localparam logic [31:0] ADDI1 = 32'h2001FFFC;
   localparam logic [31:0] ADDI2 = 32'h20017FFF;
   localparam logic [31:0] HLT   = 32'hFC000000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ins = 32'd0;
   logic [15:0] current_address = 16'd0;

   logic [15:0] jmp_loc1, jmp_loc3, ex_pc1, ex_pc3;
   logic        pc_mux_sel1, pc_mux_sel3, stall1, stall3, stall_pm1, stall_pm3;
   logic        ex_valid1, ex_valid3;
   logic [5:0]  ex_opcode1, ex_opcode3;
   logic [4:0]  ex_rs1, ex_rs3, ex_rt1, ex_rt3, ex_rd1, ex_rd3;
   logic [31:0] ex_imm1, ex_imm3;

   int vectors = 0;
   int miscompares = 0;

   ctl_t ctq1[$], ctq3[$];
   ex_t  exq1[$], exq3[$];

   always #5 clk = ~clk;

   instruction_decode_stage #(.FLUSH_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
      .jmp_loc(jmp_loc1), .pc_mux_sel(pc_mux_sel1), .stall(stall1), .stall_pm(stall_pm1),
      .ex_valid(ex_valid1), .ex_opcode(ex_opcode1), .ex_rs(ex_rs1), .ex_rt(ex_rt1),
      .ex_rd(ex_rd1), .ex_imm(ex_imm1), .ex_pc(ex_pc1)
   );

   instruction_decode_stage #(.FLUSH_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
      .jmp_loc(jmp_loc3), .pc_mux_sel(pc_mux_sel3), .stall(stall3), .stall_pm(stall_pm3),
      .ex_valid(ex_valid3), .ex_opcode(ex_opcode3), .ex_rs(ex_rs3), .ex_rt(ex_rt3),
      .ex_rd(ex_rd3), .ex_imm(ex_imm3), .ex_pc(ex_pc3)
   );

   // Every comparison funnels through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [68:0] act, input logic [68:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the control response of each instance.
   task automatic applyStimulus(input logic rst, input logic [31:0] w, input logic [15:0] a,
                                input ctl_t c1, input ctl_t c3);
      @(posedge clk);
      #1;
      reset = rst;
      ins = w;
      current_address = a;
      ctq1.push_back(c1);
      ctq3.push_back(c3);
   endtask

   task automatic expectEx(input bit d1, input bit d3, input logic [15:0] pc, input logic [5:0] op,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] imm);
      ex_t e;
      e = '{pc:pc, op:op, rs:rs, rt:rt, rd:rd, imm:imm};
      if (d1) exq1.push_back(e);
      if (d3) exq3.push_back(e);
   endtask

   // Monitor: control is compared every queued cycle, decode fields whenever ex_valid is high.
   always @(negedge clk) begin
      ctl_t c;
      ex_t  e;
      if (ctq1.size() > 0) begin
         c = ctq1.pop_front();
         checkOutput("ctl_fc1", 69'({ex_valid1, stall1, stall_pm1, pc_mux_sel1, jmp_loc1}), 69'(c));
      end
      if (ctq3.size() > 0) begin
         c = ctq3.pop_front();
         checkOutput("ctl_fc3", 69'({ex_valid3, stall3, stall_pm3, pc_mux_sel3, jmp_loc3}), 69'(c));
      end
      if (ex_valid1 === 1'b1) begin
         if (exq1.size() == 0) begin
            checkOutput("unexpected_ex_fc1", 69'({ex_pc1, ex_opcode1}), 69'h1FFFFFFFFFFFFFFFFF);
         end else begin
            e = exq1.pop_front();
            checkOutput("ex_fc1", {ex_pc1, ex_opcode1, ex_rs1, ex_rt1, ex_rd1, ex_imm1}, e);
         end
      end
      if (ex_valid3 === 1'b1) begin
         if (exq3.size() == 0) begin
            checkOutput("unexpected_ex_fc3", 69'({ex_pc3, ex_opcode3}), 69'h1FFFFFFFFFFFFFFFFF);
         end else begin
            e = exq3.pop_front();
            checkOutput("ex_fc3", {ex_pc3, ex_opcode3, ex_rs3, ex_rt3, ex_rd3, ex_imm3}, e);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset, then straight-line code, sign extension and a load-use hazard
      applyStimulus(1'b0, 32'd0, 16'd0, CZ, CZ);
      applyStimulus(1'b1, ADD1, 16'd0, CZ, CZ);
      applyStimulus(1'b1, ADD2, 16'd1, CV, CV);
      expectEx(1, 1, 16'd0, 6'h00, 5'd1, 5'd2, 5'd3, 32'h00001820);
      applyStimulus(1'b1, ADDI1, 16'd2, CV, CV);
      expectEx(1, 1, 16'd1, 6'h00, 5'd2, 5'd3, 5'd4, 32'h00002020);
      applyStimulus(1'b1, ADDI2, 16'd3, CV, CV);
      expectEx(1, 1, 16'd2, 6'h08, 5'd0, 5'd1, 5'd31, 32'hFFFFFFFC);
      applyStimulus(1'b1, LW2, 16'd4, CV, CV);
      expectEx(1, 1, 16'd3, 6'h08, 5'd0, 5'd1, 5'd15, 32'h00007FFF);
      applyStimulus(1'b1, DEP, 16'd5, CS, CS);
      expectEx(1, 1, 16'd4, 6'h23, 5'd0, 5'd2, 5'd0, 32'h00000004);
      applyStimulus(1'b1, DEP, 16'd5, CZ, CZ);
      applyStimulus(1'b1, J8, 16'd6, CV, CV);
      expectEx(1, 1, 16'd5, 6'h00, 5'd2, 5'd2, 5'd3, 32'h00001820);
      // Jump: FLUSH_CYCLES=1 resumes at once, FLUSH_CYCLES=3 shows three bubbles
      applyStimulus(1'b1, ADD1, 16'd7, CJ, CJ);
      expectEx(1, 1, 16'd6, 6'h02, 5'd0, 5'd0, 5'd0, 32'h00000008);
      applyStimulus(1'b1, ADD2, 16'd8, CZ, CZ);
      applyStimulus(1'b1, ADDI1, 16'd9, CV, CZ);
      expectEx(1, 0, 16'd8, 6'h00, 5'd2, 5'd3, 5'd4, 32'h00002020);
      applyStimulus(1'b1, HLT, 16'd10, CV, CZ);
      expectEx(1, 0, 16'd9, 6'h08, 5'd0, 5'd1, 5'd31, 32'hFFFFFFFC);
      // HALT reaches ID in both instances and holds until reset
      applyStimulus(1'b1, ADD1, 16'd11, CS, CS);
      expectEx(1, 1, 16'd10, 6'h3F, 5'd0, 5'd0, 5'd0, 32'h00000000);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, ADD1, 16'd11, CH, CH);
      end
      applyStimulus(1'b0, ADD1, 16'd11, CZ, CZ);
      applyStimulus(1'b1, ADD2, 16'd0, CZ, CZ);
      applyStimulus(1'b1, ADD1, 16'd1, CV, CV);
      expectEx(1, 1, 16'd0, 6'h00, 5'd2, 5'd3, 5'd4, 32'h00002020);
      applyStimulus(1'b1, 32'd0, 16'd2, CV, CV);
      expectEx(1, 1, 16'd1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h00001820);
      // Reset on the second flush cycle must leave no residual squash
      applyStimulus(1'b1, J8, 16'd3, CV, CV);
      expectEx(1, 1, 16'd2, 6'h00, 5'd0, 5'd0, 5'd0, 32'h00000000);
      applyStimulus(1'b1, ADD1, 16'd4, CJ, CJ);
      expectEx(1, 1, 16'd3, 6'h02, 5'd0, 5'd0, 5'd0, 32'h00000008);
      applyStimulus(1'b1, ADD2, 16'd8, CZ, CZ);
      applyStimulus(1'b0, ADDI1, 16'd9, CZ, CZ);
      applyStimulus(1'b1, ADDI2, 16'd16, CZ, CZ);
      applyStimulus(1'b1, ADD1, 16'd17, CV, CV);
      expectEx(1, 1, 16'd16, 6'h08, 5'd0, 5'd1, 5'd15, 32'h00007FFF);
      applyStimulus(1'b1, 32'd0, 16'd18, CV, CV);
      expectEx(1, 1, 16'd17, 6'h00, 5'd1, 5'd2, 5'd3, 32'h00001820);
      applyStimulus(1'b1, 32'd0, 16'd19, CV, CV);
      expectEx(1, 1, 16'd18, 6'h00, 5'd0, 5'd0, 5'd0, 32'h00000000);
      @(negedge clk);
      #1;
      checkOutput("pending_ex_fc1", 69'(exq1.size()), 69'd0);
      checkOutput("pending_ex_fc3", 69'(exq3.size()), 69'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
